// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronized line, 3-sample majority vote,
// optional parity, one or two stop bits, break and error reporting.
module uart_rx_cfg #(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50000000,
   parameter int PAYLOAD_BITS = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   output logic                    uart_rx_break,
   output logic                    uart_rx_parity_err,
   output logic                    uart_rx_frame_err
);

   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int CW = $clog2(CYCLES_PER_BIT + 1);
   localparam int BW = $clog2(PAYLOAD_BITS + 1);

   localparam logic [CW-1:0] SMP0 = CW'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] SMP1 = CW'(CYCLES_PER_BIT / 2);
   localparam logic [CW-1:0] SMP2 = CW'(CYCLES_PER_BIT / 2 + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                  state;
   logic [1:0]              sync_q;
   logic                    rxd_s;
   logic                    prime;
   logic                    armed;
   logic [CW-1:0]           cnt;
   logic [BW-1:0]           bit_cnt;
   logic [1:0]              samp;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic                    par_acc;
   logic                    par_err_q;
   logic                    all_zero;
   logic                    brk_q;
   logic                    stop_err;
   logic                    stop_idx;

   logic vote;
   logic at_mid;
   logic at_end;
   logic par_err_c;
   logic brk_c;
   logic ferr_c;
   logic last_stop;

   assign rxd_s  = sync_q[1];
   assign vote   = (samp[0] & samp[1]) | (rxd_s & (samp[0] | samp[1]));
   assign at_mid = (cnt == SMP2);
   assign at_end = (cnt == LAST);

   always_comb begin
      par_err_c = 1'b0;
      if (PARITY == 1) begin
         par_err_c = ~(par_acc ^ vote);
      end else if (PARITY == 2) begin
         par_err_c = par_acc ^ vote;
      end
   end

   // Break is decided by the first stop bit; a break never flags framing.
   assign brk_c     = stop_idx ? brk_q : (all_zero & ~vote);
   assign ferr_c    = ~brk_c & (stop_err | ~vote);
   assign last_stop = (STOP_BITS == 1) || stop_idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q             <= 2'b11;
         prime              <= 1'b0;
         armed              <= 1'b0;
         state              <= S_IDLE;
         cnt                <= '0;
         bit_cnt            <= '0;
         samp               <= 2'b00;
         shreg              <= '0;
         par_acc            <= 1'b0;
         par_err_q          <= 1'b0;
         all_zero           <= 1'b0;
         brk_q              <= 1'b0;
         stop_err           <= 1'b0;
         stop_idx           <= 1'b0;
         uart_rx_valid      <= 1'b0;
         uart_rx_data       <= '0;
         uart_rx_break      <= 1'b0;
         uart_rx_parity_err <= 1'b0;
         uart_rx_frame_err  <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], uart_rxd};
         prime         <= 1'b1;
         uart_rx_valid <= 1'b0;
         if (state == S_IDLE) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            // Only a line seen high through a loaded synchronizer re-arms.
            if (prime && rxd_s && sync_q[0]) begin
               armed <= 1'b1;
            end
            if (uart_rx_en && armed && !rxd_s) begin
               state     <= S_START;
               armed     <= 1'b0;
               all_zero  <= 1'b1;
               par_acc   <= 1'b0;
               par_err_q <= 1'b0;
               brk_q     <= 1'b0;
               stop_err  <= 1'b0;
            end
         end else if (!uart_rx_en) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            cnt <= at_end ? '0 : cnt + 1'b1;
            if (cnt == SMP0) begin
               samp[0] <= rxd_s;
            end
            if (cnt == SMP1) begin
               samp[1] <= rxd_s;
            end
            unique case (state)
               S_START: begin
                  if (at_mid && vote) begin
                     state <= S_IDLE;
                     cnt   <= '0;
                  end else if (at_end) begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (at_mid) begin
                     shreg    <= {vote, shreg[PAYLOAD_BITS-1:1]};
                     par_acc  <= par_acc ^ vote;
                     all_zero <= all_zero & ~vote;
                  end
                  if (at_end) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) begin
                        state <= (PARITY != 0) ? S_PARITY : S_STOP;
                     end
                  end
               end
               S_PARITY: begin
                  if (at_mid) begin
                     par_err_q <= par_err_c;
                     all_zero  <= all_zero & ~vote;
                  end
                  if (at_end) begin
                     state <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (at_mid) begin
                     if (last_stop) begin
                        uart_rx_valid      <= 1'b1;
                        uart_rx_data       <= shreg;
                        uart_rx_break      <= brk_c;
                        uart_rx_parity_err <= par_err_q;
                        uart_rx_frame_err  <= ferr_c;
                        state              <= S_IDLE;
                        cnt                <= '0;
                     end else begin
                        brk_q    <= brk_c;
                        stop_err <= ~vote;
                        stop_idx <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 receiver and an 8E2 receiver at 9600 baud,
// checked against a frame-level model of the line protocol.
module tb_uart_rx_cfg;

   localparam int CLK_HZ   = 153600;
   localparam int BIT_RATE = 9600;
   localparam int CPB      = CLK_HZ / BIT_RATE;

   typedef struct {
      logic [7:0] data;
      logic       brk;
      logic       perr;
      logic       ferr;
      int         lo;
      int         hi;
   } exp_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx_en = 1'b0;
   logic       rxd_a = 1'b1;
   logic       rxd_b = 1'b1;
   logic       v_a, brk_a, pe_a, fe_a;
   logic       v_b, brk_b, pe_b, fe_b;
   logic [7:0] d_a, d_b;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int pulses_a = 0;
   int pulses_b = 0;

   exp_t       q_a[$];
   exp_t       q_b[$];
   logic [7:0] ld_a = '0;
   logic [7:0] ld_b = '0;
   logic [2:0] lf_a = '0;
   logic [2:0] lf_b = '0;

   uart_rx_cfg #(
      .BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8),
      .PARITY(0), .STOP_BITS(1)
   ) u_a (
      .clk(clk), .reset(reset), .uart_rxd(rxd_a), .uart_rx_en(rx_en),
      .uart_rx_valid(v_a), .uart_rx_data(d_a), .uart_rx_break(brk_a),
      .uart_rx_parity_err(pe_a), .uart_rx_frame_err(fe_a)
   );

   uart_rx_cfg #(
      .BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8),
      .PARITY(2), .STOP_BITS(2)
   ) u_b (
      .clk(clk), .reset(reset), .uart_rxd(rxd_b), .uart_rx_en(rx_en),
      .uart_rx_valid(v_b), .uart_rx_data(d_b), .uart_rx_break(brk_b),
      .uart_rx_parity_err(pe_b), .uart_rx_frame_err(fe_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level result of a line bit pattern (bit 0 = start bit).
   function automatic exp_t model(input logic [15:0] fr, input int par,
                                  input int nstop, input int t0);
      exp_t e;
      logic [7:0] dt;
      logic pb, s1, s2, x;
      int nb;
      for (int i = 0; i < 8; i++) dt[i] = fr[1+i];
      pb = (par != 0) ? fr[9] : 1'b0;
      nb = 9 + ((par != 0) ? 1 : 0) + nstop;
      s1 = fr[nb-nstop];
      s2 = fr[nb-1];
      x = (^dt) ^ pb;
      e.data = dt;
      e.brk  = (dt == 8'h00) && !pb && !s1;
      e.ferr = !e.brk && (!s1 || !s2);
      e.perr = (par == 1) ? !x : (par == 2) ? x : 1'b0;
      e.lo   = t0 + (nb - 1) * CPB + CPB / 2;
      e.hi   = t0 + nb * CPB;
      return e;
   endfunction

   function automatic logic [15:0] mk(input logic [7:0] b, input int par,
                                      input logic flip, input int nstop,
                                      input logic [1:0] stv);
      logic [15:0] fr;
      int idx;
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[1+i] = b[i];
      idx = 9;
      if (par != 0) begin
         fr[9] = ((par == 1) ? ~(^b) : (^b)) ^ flip;
         idx = 10;
      end
      fr[idx] = stv[0];
      if (nstop == 2) fr[idx+1] = stv[1];
      return fr;
   endfunction

   task automatic lit(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, req);
      end
   endtask

   task automatic chk_one(input int k, input logic v, input logic [7:0] d,
                          input logic [2:0] f);
      exp_t e;
      logic [10:0] held;
      if (v) begin
         if (k == 0) pulses_a++; else pulses_b++;
         tests++;
         if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
            fails++;
            $display("FAIL pulse_%0d: unexpected valid at cycle %0d data %h", k, cyc, d);
            if (k == 0) begin ld_a = d; lf_a = f; end
            else begin ld_b = d; lf_b = f; end
         end else begin
            if (k == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            tests++;
            if (d !== e.data) begin
               fails++;
               $display("FAIL data_%0d: got %h, want %h", k, d, e.data);
            end
            tests++;
            if (f !== {e.brk, e.perr, e.ferr}) begin
               fails++;
               $display("FAIL flags_%0d: got %b, want %b (brk,perr,ferr)",
                        k, f, {e.brk, e.perr, e.ferr});
            end
            tests++;
            if (cyc < e.lo || cyc > e.hi) begin
               fails++;
               $display("FAIL timing_%0d: valid at %0d, want %0d..%0d", k, cyc, e.lo, e.hi);
            end
            if (k == 0) begin ld_a = e.data; lf_a = {e.brk, e.perr, e.ferr}; end
            else begin ld_b = e.data; lf_b = {e.brk, e.perr, e.ferr}; end
         end
      end else begin
         held = (k == 0) ? {ld_a, lf_a} : {ld_b, lf_b};
         tests++;
         if ({d, f} !== held) begin
            fails++;
            $display("FAIL hold_%0d: got %h, want %h at cycle %0d", k, {d, f}, held, cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         tests++;
         if ({v_a, d_a, brk_a, pe_a, fe_a} !== 12'h000) begin
            fails++;
            $display("FAIL reset_a: got %h, want 000", {v_a, d_a, brk_a, pe_a, fe_a});
         end
         tests++;
         if ({v_b, d_b, brk_b, pe_b, fe_b} !== 12'h000) begin
            fails++;
            $display("FAIL reset_b: got %h, want 000", {v_b, d_b, brk_b, pe_b, fe_b});
         end
         ld_a = '0; lf_a = '0;
         ld_b = '0; lf_b = '0;
      end else begin
         chk_one(0, v_a, d_a, {brk_a, pe_a, fe_a});
         chk_one(1, v_b, d_b, {brk_b, pe_b, fe_b});
      end
   end

   task automatic set_line(input int k, input logic b);
      if (k == 0) rxd_a = b; else rxd_b = b;
   endtask

   task automatic idle(input int nbits);
      repeat (nbits * CPB) @(posedge clk);
      #1;
   endtask

   // Drive nb bit periods of fr; optionally drop enable or pulse reset
   // in the middle of bit en_bit / rst_bit.
   task automatic send(input int k, input logic [15:0] fr, input int nb,
                       input bit push, input int en_bit, input int rst_bit);
      exp_t e;
      int t0;
      bit aborted;
      aborted = 0;
      @(posedge clk);
      #1;
      t0 = cyc;
      if (push) begin
         if (k == 0) begin
            e = model(fr, 0, 1, t0);
            q_a.push_back(e);
         end else begin
            e = model(fr, 2, 2, t0);
            q_b.push_back(e);
         end
      end
      for (int i = 0; i < nb && !aborted; i++) begin
         set_line(k, fr[i]);
         for (int c = 0; c < CPB; c++) begin
            if (i == en_bit && c == CPB / 2) rx_en = 1'b0;
            if (i == rst_bit && c == CPB / 2) reset = 1'b1;
            if (i == rst_bit && c == CPB / 2 + 3) begin
               reset = 1'b0;
               set_line(k, 1'b1);
               aborted = 1;
            end
            @(posedge clk);
            #1;
         end
      end
      set_line(k, 1'b1);
      rx_en = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t pe;
      pe = model(mk(8'h41, 2, 1'b0, 2, 2'b11), 2, 2, 0);
      lit("model_even_ok", int'(pe.perr), 0);
      pe = model(mk(8'h41, 2, 1'b1, 2, 2'b11), 2, 2, 0);
      lit("model_even_bad", int'(pe.perr), 1);
      pe = model(16'h0000, 0, 1, 0);
      lit("model_break", int'({pe.brk, pe.ferr}), 2);

      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      lit("rst_valid_a", int'(v_a), 0);
      lit("rst_data_a", int'(d_a), 0);
      lit("rst_flags_b", int'({brk_b, pe_b, fe_b}), 0);
      rx_en = 1'b1;
      idle(2);

      send(0, mk(8'h41, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      send(0, mk(8'h42, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      send(0, mk(8'h43, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      idle(1);
      send(0, mk(8'h44, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      idle(2);
      lit("bytes_pulses", pulses_a, 4);
      lit("bytes_last", int'(d_a), 8'h44);

      send(1, mk(8'h41, 2, 1'b0, 2, 2'b11), 12, 1, -1, -1);
      idle(2);
      lit("par_ok", int'(pe_b), 0);
      send(1, mk(8'h41, 2, 1'b1, 2, 2'b11), 12, 1, -1, -1);
      idle(2);
      lit("par_bad", int'(pe_b), 1);
      lit("par_bad_data", int'(d_b), 8'h41);
      send(1, mk(8'hC3, 2, 1'b0, 2, 2'b01), 12, 1, -1, -1);
      idle(2);
      lit("stop2_ferr", int'(fe_b), 1);

      send(0, mk(8'h55, 0, 1'b0, 1, 2'b00), 10, 1, -1, -1);
      idle(2);
      lit("stop0_ferr", int'(fe_a), 1);
      lit("stop0_brk", int'(brk_a), 0);
      lit("stop0_data", int'(d_a), 8'h55);

      send(0, 16'h0000, 12, 1, -1, -1);
      idle(2);
      lit("break_flag", int'(brk_a), 1);
      lit("break_pulses", pulses_a, 6);
      send(0, mk(8'h5A, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      idle(2);
      lit("after_break", int'({d_a, brk_a}), {8'h5A, 1'b0});

      @(posedge clk);
      #1;
      rxd_a = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rxd_a = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      send(0, mk(8'h3C, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      idle(2);
      lit("glitch_pulses", pulses_a, 8);
      lit("glitch_data", int'(d_a), 8'h3C);

      send(0, mk(8'h99, 0, 1'b0, 1, 2'b11), 10, 0, 4, -1);
      idle(2);
      lit("en_abort", pulses_a, 8);
      send(0, mk(8'h7E, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      idle(2);
      lit("en_next", int'(d_a), 8'h7E);

      send(0, mk(8'h99, 0, 1'b0, 1, 2'b11), 10, 0, -1, 6);
      idle(2);
      lit("rst_abort", pulses_a, 9);
      lit("rst_clear", int'(d_a), 0);
      send(0, mk(8'h7E, 0, 1'b0, 1, 2'b11), 10, 1, -1, -1);
      idle(2);
      lit("rst_next", int'(d_a), 8'h7E);

      lit("left_a", q_a.size(), 0);
      lit("left_b", q_b.size(), 0);
      lit("total_a", pulses_a, 10);
      lit("total_b", pulses_b, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
